riscv_divider: RTL and testbench

//   Multi-cycle iterative restoring divider for the RISC-V core (M extension DIV/DIVU/REM/REMU).

---
 rtl/riscv_div_pkg.sv | 29 ++
 rtl/riscv_divider_if.sv | 28 ++
 rtl/riscv_div_step.sv | 26 ++
 rtl/riscv_divider.sv | 167 ++++++++++++++++
 tb/tb_riscv_divider.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_div_pkg.sv
// Shared types for the iterative RISC-V divider: op encodings, FSM states, defaults.
package riscv_div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_TAG_W = 5;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // funct3[0] clear means signed, funct3[1] set means remainder
    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/riscv_divider_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface riscv_divider_if
    import riscv_div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
);
    logic             in_valid;
    logic             in_ready;
    div_op_e          in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/riscv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module riscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    logic [XLEN:0]   rem_shift_s;
    logic [XLEN-1:0] diff_s;

    // The shifted remainder can exceed XLEN bits, so compare at XLEN+1; the difference always fits
    always_comb begin
        rem_shift_s = {rem_in, dvd_msb};
        diff_s      = rem_shift_s[XLEN-1:0] - divisor;
        if (rem_shift_s >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = diff_s;
        end else begin
            q_bit   = 1'b0;
            rem_out = rem_shift_s[XLEN-1:0];
        end
    end
endmodule

// File: rtl/riscv_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional RISCV_DIV_FASTPATH_EN: divide-by-zero and signed overflow complete straight from IDLE.
module riscv_divider
    import riscv_div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    riscv_divider_if.slave div_if
);
    localparam int              CNT_W    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    div_state_e       state_r;
    div_op_e          op_r;
    logic [TAG_W-1:0] tag_r;
    logic             q_neg_r, r_neg_r, b_zero_r;
    logic [XLEN-1:0]  dvd_r, rem_r, divisor_r;
    logic [CNT_W-1:0] cnt_r;
    logic             in_ready_r, out_valid_r;
    logic [XLEN-1:0]  out_result_r;
    logic [TAG_W-1:0] out_tag_r;

    logic             a_neg_s, b_neg_s, b_zero_s;
    logic [XLEN-1:0]  abs_a_s, abs_b_s, q_fin_s, r_fin_s, step_rem_s;
    logic             step_q_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        if (neg) begin
            return ~v + ONE;
        end else begin
            return v;
        end
    endfunction

    riscv_div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_r),
        .dvd_msb (dvd_r[XLEN-1]),
        .divisor (divisor_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Operand magnitudes at accept; sign-corrected results at completion
    always_comb begin
        a_neg_s  = op_is_signed(div_if.in_op) & div_if.in_a[XLEN-1];
        b_neg_s  = op_is_signed(div_if.in_op) & div_if.in_b[XLEN-1];
        abs_a_s  = cond_neg(a_neg_s, div_if.in_a);
        abs_b_s  = cond_neg(b_neg_s, div_if.in_b);
        b_zero_s = (div_if.in_b == ZERO);
        // Divide by zero leaves an all-ones quotient regardless of operand signs
        q_fin_s  = cond_neg(q_neg_r & ~b_zero_r, dvd_r);
        r_fin_s  = cond_neg(r_neg_r, rem_r);
    end

`ifdef RISCV_DIV_FASTPATH_EN
    logic            special_s;
    logic [XLEN-1:0] special_res_s;

    // Results of the two operand patterns that need no iteration
    always_comb begin
        special_s = b_zero_s |
                    (op_is_signed(div_if.in_op) &&
                     (div_if.in_a == {1'b1, {(XLEN-1){1'b0}}}) && (div_if.in_b == ALL_ONES));
        if (b_zero_s) begin
            special_res_s = op_is_rem(div_if.in_op) ? div_if.in_a : ALL_ONES;
        end else begin
            special_res_s = op_is_rem(div_if.in_op) ? ZERO : div_if.in_a;
        end
    end
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            op_r         <= OP_DIV;
            tag_r        <= {TAG_W{1'b0}};
            q_neg_r      <= 1'b0;
            r_neg_r      <= 1'b0;
            b_zero_r     <= 1'b0;
            dvd_r        <= ZERO;
            rem_r        <= ZERO;
            divisor_r    <= ZERO;
            cnt_r        <= CNT_ZERO;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= ZERO;
            out_tag_r    <= {TAG_W{1'b0}};
        end else if (flush) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (div_if.in_valid && in_ready_r) begin
                        op_r       <= div_if.in_op;
                        tag_r      <= div_if.in_tag;
                        q_neg_r    <= a_neg_s ^ b_neg_s;
                        r_neg_r    <= a_neg_s;
                        b_zero_r   <= b_zero_s;
                        dvd_r      <= abs_a_s;
                        divisor_r  <= abs_b_s;
                        rem_r      <= ZERO;
                        cnt_r      <= CNT_ZERO;
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
`ifdef RISCV_DIV_FASTPATH_EN
                        if (special_s) begin
                            out_result_r <= special_res_s;
                            out_tag_r    <= div_if.in_tag;
                            out_valid_r  <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            out_valid_r  <= 1'b0;
                        end
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_r == CNT_LAST) begin
                        out_result_r <= op_is_rem(op_r) ? r_fin_s : q_fin_s;
                        out_tag_r    <= tag_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        // Quotient bits fill the dividend register as its bits are consumed
                        rem_r <= step_rem_s;
                        dvd_r <= {dvd_r[XLEN-2:0], step_q_s};
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (div_if.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign div_if.in_ready   = in_ready_r;
    assign div_if.out_valid  = out_valid_r;
    assign div_if.out_result = out_result_r;
    assign div_if.out_tag    = out_tag_r;
endmodule

// File: tb/tb_riscv_divider.sv
// Directed self-checking bench for riscv_divider (latency, results, hold, flush, reset).
module tb_riscv_divider;
    import riscv_div_pkg::*;

`ifdef RISCV_DIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int NORMAL_LAT = 33;

    logic clk, reset, flush;
    int   checks = 0;
    int   errors = 0;

    riscv_divider_if #(.XLEN(32), .TAG_W(5)) dif ();

    riscv_divider #(.XLEN(32), .TAG_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        dif.in_valid = 1'b1;
        dif.in_op    = op;
        dif.in_a     = a;
        dif.in_b     = b;
        dif.in_tag   = tag;
        step();
        dif.in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat, input logic [31:0] exp_res,
                               input logic [4:0] exp_tag);
        int cycles = 1;
        while (!dif.out_valid && cycles < 100) begin
            step();
            cycles++;
        end
        if (dif.out_valid !== 1'b1) cycles = 1000;
        check({name, "_lat"}, cycles, exp_lat);
        check({name, "_res"}, dif.out_result, exp_res);
        check({name, "_tag"}, {27'd0, dif.out_tag}, {27'd0, exp_tag});
    endtask

    task automatic retire(input string name);
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;
        check({name, "_ovalid_clr"}, {31'd0, dif.out_valid}, 32'd0);
        check({name, "_iready_set"}, {31'd0, dif.in_ready}, 32'd1);
    endtask

    task automatic do_op(input string name, input div_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp_res, input int exp_lat);
        issue(op, a, b, tag);
        if (exp_lat > 1) check({name, "_busy_iready"}, {31'd0, dif.in_ready}, 32'd0);
        if (exp_lat > 1) step();
        wait_result(name, exp_lat, exp_res, tag);
        retire(name);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        flush = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_op     = OP_DIV;
        dif.in_a      = 32'd0;
        dif.in_b      = 32'd0;
        dif.in_tag    = 5'd0;
        dif.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_iready", {31'd0, dif.in_ready}, 32'd1);
        check("rst_ovalid", {31'd0, dif.out_valid}, 32'd0);
        check("rst_result", dif.out_result, 32'd0);
        check("rst_tag", {27'd0, dif.out_tag}, 32'd0);

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, NORMAL_LAT);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, NORMAL_LAT);
        do_op("div_m7_2",   OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, NORMAL_LAT);
        do_op("rem_m7_2",   OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, NORMAL_LAT);
        do_op("div_7_m2",   OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, NORMAL_LAT);
        do_op("rem_7_m2",   OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, NORMAL_LAT);
        do_op("div_5_0",    OP_DIV, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, SPECIAL_LAT);
        do_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 5'd10, 32'd5, SPECIAL_LAT);
        do_op("div_m5_0",   OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, SPECIAL_LAT);
        do_op("rem_m5_0",   OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, SPECIAL_LAT);
        do_op("div_ovf",    OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, SPECIAL_LAT);
        do_op("rem_ovf",    OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, SPECIAL_LAT);
        do_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd15, 32'hFFFF_FFFF, NORMAL_LAT);
        do_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd16, 32'h0000_000F, NORMAL_LAT);
        do_op("divu_ovf_u", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, NORMAL_LAT);

        // Result held while the consumer stalls
        issue(OP_DIVU, 32'd1000, 32'd10, 5'd21);
        step();
        wait_result("hold", NORMAL_LAT, 32'd100, 5'd21);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_ovalid", {31'd0, dif.out_valid}, 32'd1);
            check("hold_result", dif.out_result, 32'd100);
            check("hold_tag", {27'd0, dif.out_tag}, 32'd21);
            check("hold_iready", {31'd0, dif.in_ready}, 32'd0);
        end
        retire("hold");

        // Flush in the middle of an iteration
        issue(OP_DIVU, 32'd500, 32'd5, 5'd22);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_iready", {31'd0, dif.in_ready}, 32'd1);
        check("flush_ovalid", {31'd0, dif.out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dif.out_valid) seen++;
        end
        check("flush_no_valid", seen, 32'd0);

        // Flush wins over a simultaneous accept
        dif.in_valid = 1'b1;
        dif.in_op    = OP_DIVU;
        dif.in_a     = 32'd9;
        dif.in_b     = 32'd3;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        dif.in_valid = 1'b0;
        check("flush_accept_iready", {31'd0, dif.in_ready}, 32'd1);
        step();
        check("flush_accept_ovalid", {31'd0, dif.out_valid}, 32'd0);

        // Flush wins over a simultaneous result handshake
        issue(OP_DIVU, 32'd81, 32'd9, 5'd23);
        step();
        wait_result("flush_done", NORMAL_LAT, 32'd9, 5'd23);
        dif.out_ready = 1'b1;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        dif.out_ready = 1'b0;
        check("flush_done_ovalid", {31'd0, dif.out_valid}, 32'd0);
        check("flush_done_iready", {31'd0, dif.in_ready}, 32'd1);

        // Reset mid-iteration clears outputs
        issue(OP_DIVU, 32'd64, 32'd4, 5'd24);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_iready", {31'd0, dif.in_ready}, 32'd1);
        check("rst_mid_ovalid", {31'd0, dif.out_valid}, 32'd0);
        check("rst_mid_result", dif.out_result, 32'd0);
        check("rst_mid_tag", {27'd0, dif.out_tag}, 32'd0);

        do_op("after_rst", OP_DIVU, 32'd64, 32'd4, 5'd25, 32'd16, NORMAL_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
